regfile_write_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback requesters:
//  A (load/burst unit) and B (ALU writeback). Arbitration is round-robin, with a burst

---
 rtl/regfile_write_arbiter.sv | 97 +++++++++
 tb/tb_regfile_write_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester write-port arbiter for the register file
// Round-robin between A and B, with an A burst lock and a B starvation guard, feeding a 1-entry output stage.
module regfile_write_arbiter #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  input  logic                 a_lock,
  input  logic [ADDR_W-1:0]    a_rd,
  input  logic [DATA_W-1:0]    a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [ADDR_W-1:0]    b_rd,
  input  logic [DATA_W-1:0]    b_data,
  output logic                 b_ready,
  output logic                 reg_write,
  output logic [ADDR_W-1:0]    wr_rd,
  output logic [DATA_W-1:0]    wr_data,
  output logic [2**ADDR_W-1:0] wr_busy,
  output logic [7:0]           conflict_cnt
);

  typedef enum logic {RR_A = 1'b0, RR_B = 1'b1} rr_t;

  rr_t        rr_ptr, rr_next;
  logic [3:0] b_wait, b_wait_next;
  logic       both, b_force, a_pri, a_grant, b_grant;

  // a_pri: A wins a contested cycle; the starvation guard overrides both lock and pointer
  always_comb begin
    both     = a_valid & b_valid;
    b_force  = (b_wait == 4'(MAX_WAIT));
    a_pri    = !b_force && (a_lock || (rr_ptr == RR_A));
    a_grant  = rst_n && a_valid && (!b_valid || a_pri);
    b_grant  = rst_n && b_valid && (!a_valid || !a_pri);
    a_ready  = a_grant;
    b_ready  = b_grant;
  end

  always_comb begin
    rr_next     = rr_ptr;
    b_wait_next = b_wait;
    if (a_grant)
      rr_next = RR_B;
    else if (b_grant)
      rr_next = RR_A;
    if (!b_valid || b_grant)
      b_wait_next = 4'd0;
    else if (b_wait != 4'(MAX_WAIT))
      b_wait_next = b_wait + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= RR_A;
      b_wait <= 4'd0;
    end else begin
      rr_ptr <= rr_next;
      b_wait <= b_wait_next;
    end
  end

  // wr_rd/wr_data hold their last value when no grant occurs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write <= 1'b0;
      wr_rd     <= '0;
      wr_data   <= '0;
    end else begin
      reg_write <= a_grant | b_grant;
      if (a_grant) begin
        wr_rd   <= a_rd;
        wr_data <= a_data;
      end else if (b_grant) begin
        wr_rd   <= b_rd;
        wr_data <= b_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      conflict_cnt <= 8'd0;
    else if (both && (conflict_cnt != 8'hFF))
      conflict_cnt <= conflict_cnt + 8'd1;
  end

  always_comb begin
    wr_busy = '0;
    if (reg_write)
      wr_busy[wr_rd] = 1'b1;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  localparam int MAX_WAIT = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, a_lock, b_valid;
  logic [1:0] a_rd, b_rd;
  logic [3:0] a_data, b_data;
  logic       a_ready, b_ready, reg_write;
  logic [1:0] wr_rd;
  logic [3:0] wr_data, wr_busy;
  logic [7:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_q[$];
  logic [3:0] rf[4];
  logic       m_rr;
  int         m_wait;
  int         m_conf;
  logic       ga_s, gb_s;

  regfile_write_arbiter #(.DATA_W(4), .ADDR_W(2), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_lock(a_lock), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .reg_write(reg_write), .wr_rd(wr_rd), .wr_data(wr_data), .wr_busy(wr_busy),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model and output scoreboard, evaluated mid-cycle
  always @(negedge clk) begin
    logic       ga, gb;
    logic [5:0] e;
    if (!rst_n) begin
      exp_q.delete();
      m_rr   = 1'b0;
      m_wait = 0;
      m_conf = 0;
      check("rst_a_ready", int'(a_ready), 0);
      check("rst_b_ready", int'(b_ready), 0);
    end else begin
      check("reg_write", int'(reg_write), int'(exp_q.size() != 0));
      if (reg_write && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_rd", int'(wr_rd), int'(e[5:4]));
        check("wr_data", int'(wr_data), int'(e[3:0]));
        check("wr_busy", int'(wr_busy), 1 << e[5:4]);
        rf[wr_rd] = wr_data;
      end else begin
        check("wr_busy_idle", int'(wr_busy), 0);
      end
      check("conflict_cnt", int'(conflict_cnt), m_conf);

      ga = a_valid && (!b_valid || (m_wait != MAX_WAIT && (a_lock || m_rr == 1'b0)));
      gb = b_valid && !ga;
      check("a_ready", int'(a_ready), int'(ga));
      check("b_ready", int'(b_ready), int'(gb));
      if (ga) exp_q.push_back({a_rd, a_data});
      if (gb) exp_q.push_back({b_rd, b_data});

      if (ga) m_rr = 1'b1;
      else if (gb) m_rr = 1'b0;
      if (!b_valid || gb) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
      if (a_valid && b_valid && m_conf < 255) m_conf++;
    end
  end

  task automatic step();
    @(negedge clk);
    ga_s = a_ready;
    gb_s = b_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic av, input logic al, input logic [1:0] ar, input logic [3:0] ad,
                         input logic bv, input logic [1:0] br, input logic [3:0] bd);
    a_valid = av; a_lock = al; a_rd = ar; a_data = ad;
    b_valid = bv; b_rd = br; b_data = bd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic pat3 [5];
    pat3 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    rst_n = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    a_valid = 1'b1;
    #1;
    check("reset_reg_write", int'(reg_write), 0);
    check("reset_wr_rd", int'(wr_rd), 0);
    check("reset_wr_data", int'(wr_data), 0);
    check("reset_wr_busy", int'(wr_busy), 0);
    check("reset_conflict", int'(conflict_cnt), 0);
    check("reset_a_ready", int'(a_ready), 0);
    a_valid = 1'b0;
    rst_n = 1'b1;

    // A alone
    set_req(1, 0, 2'd2, 4'd5, 0, 0, 0);
    step();
    check("t1_a_ready", int'(ga_s), 1);
    check("t1_reg_write", int'(reg_write), 1);
    check("t1_wr_rd", int'(wr_rd), 2);
    check("t1_wr_data", int'(wr_data), 5);
    check("t1_wr_busy", int'(wr_busy), 4);
    a_valid = 1'b0;
    step();
    check("t1_reg_write_off", int'(reg_write), 0);
    check("t1_wr_busy_off", int'(wr_busy), 0);

    // Round-robin alternation
    do_reset();
    set_req(1, 0, 2'd1, 4'd6, 1, 2'd3, 4'd10);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_grant_a", int'(ga_s), int'(i % 2 == 0));
      check("t2_reg_write", int'(reg_write), 1);
    end
    check("t2_conflict", int'(conflict_cnt), 4);
    set_req(0, 0, 0, 0, 0, 0, 0);
    step();

    // A lock with starvation guard
    do_reset();
    set_req(1, 1, 2'd0, 4'd1, 1, 2'd2, 4'd7);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_grant_a", int'(ga_s), int'(pat3[i]));
      if (i == 3) check("t3_b_wait_cleared", int'(dut.b_wait), 0);
    end
    set_req(0, 0, 0, 0, 0, 0, 0);
    step();

    // Conflict counter saturation
    do_reset();
    set_req(1, 0, 2'd1, 4'd2, 1, 2'd2, 4'd3);
    repeat (300) step();
    check("t4_conflict_sat", int'(conflict_cnt), 255);
    set_req(0, 0, 0, 0, 0, 0, 0);
    step();

    // Same destination register, grant order preserved
    do_reset();
    set_req(1, 0, 2'd1, 4'd3, 1, 2'd1, 4'd9);
    step();
    check("t5_first_a", int'(ga_s), 1);
    check("t5_first_data", int'(wr_data), 3);
    a_valid = 1'b0;
    step();
    check("t5_second_b", int'(gb_s), 1);
    check("t5_second_data", int'(wr_data), 9);
    b_valid = 1'b0;
    step();
    check("t5_rf1", int'(rf[1]), 9);

    // Reset while the output stage holds a write
    do_reset();
    set_req(1, 0, 2'd0, 4'd7, 1, 2'd3, 4'd4);
    step();
    check("t6_pre_reg_write", int'(reg_write), 1);
    check("t6_pre_conflict", int'(conflict_cnt), 1);
    rst_n = 1'b0;
    #1;
    check("t6_reg_write", int'(reg_write), 0);
    check("t6_wr_busy", int'(wr_busy), 0);
    check("t6_conflict", int'(conflict_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("t6_a_first", int'(ga_s), 1);

    // Random traffic; a requester's rd/data only changes once it has been granted
    for (int i = 0; i < 400; i++) begin
      if (!a_valid || ga_s) begin
        a_valid = 1'($urandom_range(0, 1));
        a_rd    = 2'($urandom);
        a_data  = 4'($urandom);
      end
      if (!b_valid || gb_s) begin
        b_valid = 1'($urandom_range(0, 1));
        b_rd    = 2'($urandom);
        b_data  = 4'($urandom);
      end
      a_lock = ($urandom_range(0, 3) != 0);
      step();
    end
    set_req(0, 0, 0, 0, 0, 0, 0);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
